coco_timer_mc: RTL and testbench
================================

// Module: coco_timer_mc
// PURPOSE
//   Multi-channel programmable down-counter timer. It replaces the single-channel
//   bus timer on the CPU peripheral bus.
//   Each channel has its own CTRL/PRESET/COUNT/STATUS registers and supports
//   one-shot and auto-reload modes, with a per-channel interrupt mask.
//   A single combined irq line drives the CP0 interrupt input.
// PARAMETERS
//   N_CH   4   number of timer channels (1..8)
//   CNT_W  32  counter/preset width in bits (8..32)
//   CH_W   2   channel-select width; must equal ceil(log2(N_CH)), minimum 1
// PORTS
//   clk_i  in   1          clock; all state updates on rising edge
//   rst_i  in   1          reset, asynchronous, active-high
//   add_i  in   CH_W+2     word address: [CH_W+1:2]=channel, [1:0]=register
//   we_i   in   1          write enable, single-cycle write strobe
//   dat_i  in   32         write data; bits above CNT_W ignored for PRESET/COUNT
//   dat_o  out  32         read data, combinational from add_i
//   irq    out  1          OR over channels of (PEND & CTRL.IM), registered
// BEHAVIOUR
//   Register map per channel (add_i[1:0]):
//     0 CTRL: [0]EN, [2:1]MODE, [3]IM; other bits read 0.
//     1 PRESET; 2 COUNT; 3 STATUS: [0]PEND.
//   MODE values:
//     00 one-shot; 01 auto-reload; 1x reserved, behaves as one-shot.
//   Reads:
//     PRESET/COUNT zero-extended to 32b.
//     Channel index >= N_CH reads 32'h0 and ignores writes.
//   Reset: all CTRL/PRESET/COUNT/PEND = 0 and irq = 0, immediately (async).
//   Per-channel state per cycle, writes evaluated before counting:
//     - Write PRESET: PRESET<=d, COUNT<=d, PEND<=0. No decrement that cycle.
//     - Write COUNT: COUNT<=d. No decrement that cycle.
//     - Write CTRL: takes effect from the next cycle.
//       Writing EN=0 freezes COUNT immediately (no decrement that cycle).
//     - Write STATUS with d[0]=1: PEND<=0 (W1C). d[0]=0 has no effect.
//     - Counting: if EN=1 and COUNT>1 and no PRESET/COUNT write, COUNT<=COUNT-1.
//     - Terminal (EN=1, COUNT==1, no PRESET/COUNT write):
//       PEND<=1; MODE01 -> COUNT<=PRESET; one-shot -> COUNT<=0 and EN<=0.
//     - EN=1 with COUNT==0 is idle: no decrement, no PEND, no reload.
//   Period: auto-reload with PRESET=P (P>=1) sets PEND every P cycles.
//     P=1 sets PEND every cycle.
//   Latency:
//     - PEND visible in STATUS the cycle after the terminal edge.
//     - irq asserts one cycle after PEND (registered OR).
//     - irq deasserts one cycle after PEND or IM clears.
//   Simultaneous terminal event and STATUS W1C on the same channel: set wins, PEND=1.
//   Other channels are never affected by a write to another channel.
//   No wrap-around: COUNT never decrements below 0.
//   Reset mid-count: all channels stop at 0 with irq low.
//     Nothing resumes until software rewrites the registers.
// TESTING
//   1 Reset: assert rst_i mid-count (ch0 COUNT=5, EN=1) -> all regs 0, irq=0 same cycle.
//   2 One-shot: ch0 PRESET=3, CTRL=0x9 ->
//     COUNT 3,2,1,0; PEND=1 at cycle 3; irq at cycle 4; EN reads 0; COUNT stays 0.
//   3 Auto-reload: ch1 PRESET=4, CTRL=0xB -> PEND set at cycles 4, 8, 12.
//     W1C at cycle 6 clears PEND until cycle 8.
//   4 W1C collision: ch2 STATUS write 1 on the terminal cycle -> PEND remains 1, irq stays high.
//   5 Mask/multi-channel:
//     ch0 IM=0 with PEND=1 -> irq=0.
//     ch3 IM=1 terminal -> irq=1.
//     Clear ch3 PEND -> irq=0 next cycle; ch0 PEND is unchanged.
//   6 Boundaries:
//     - PRESET=0 with EN=1 -> no PEND ever.
//     - CNT_W=8 write dat_i=0x1FF -> COUNT reads 0xFF.
//     - N_CH=3: address channel 3 -> reads 0, write ignored.

Source files
------------

// File: rtl/coco_timer_mc.sv
// Multi-channel down-counter timer with one-shot/auto-reload modes.
// Per-channel CTRL/PRESET/COUNT/STATUS, combined registered irq.
module coco_timer_mc #(
    parameter int N_CH  = 4,
    parameter int CNT_W = 32,
    parameter int CH_W  = 2
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic [CH_W+1:0] add_i,
    input  logic            we_i,
    input  logic [31:0]     dat_i,
    output logic [31:0]     dat_o,
    output logic            irq
);

    localparam logic [1:0] REG_CTRL   = 2'd0;
    localparam logic [1:0] REG_PRESET = 2'd1;
    localparam logic [1:0] REG_COUNT  = 2'd2;
    localparam logic [1:0] REG_STATUS = 2'd3;

    logic [N_CH-1:0]  r_en;
    logic [N_CH-1:0]  r_im;
    logic [N_CH-1:0]  r_pend;
    logic [1:0]       r_mode   [N_CH];
    logic [CNT_W-1:0] r_preset [N_CH];
    logic [CNT_W-1:0] r_count  [N_CH];
    logic             r_irq;

    logic [CH_W-1:0]  w_ch;
    logic [1:0]       w_reg;
    logic [CNT_W-1:0] w_d;
    logic             w_frz;
    logic [N_CH-1:0]  w_hit;
    logic [N_CH-1:0]  w_tick;
    logic             w_unused;

    assign w_ch     = add_i[CH_W+1:2];
    assign w_reg    = add_i[1:0];
    assign w_d      = dat_i[CNT_W-1:0];
    assign w_unused = ^dat_i;
    assign irq      = r_irq;

    // Counter-affecting writes, and EN=0 writes, suppress counting this cycle
    assign w_frz = (w_reg == REG_PRESET) || (w_reg == REG_COUNT) ||
                   ((w_reg == REG_CTRL) && !dat_i[0]);

    always_comb begin
        w_hit  = '0;
        w_tick = '0;
        for (int i = 0; i < N_CH; i++) begin
            w_hit[i]  = we_i && (w_ch == CH_W'(i));
            w_tick[i] = r_en[i] && !(w_hit[i] && w_frz);
        end
    end

    always_comb begin
        dat_o = '0;
        for (int i = 0; i < N_CH; i++) begin
            if (w_ch == CH_W'(i)) begin
                case (w_reg)
                    REG_CTRL:   dat_o = {28'd0, r_im[i], r_mode[i], r_en[i]};
                    REG_PRESET: dat_o = 32'(r_preset[i]);
                    REG_COUNT:  dat_o = 32'(r_count[i]);
                    default:    dat_o = {31'd0, r_pend[i]};
                endcase
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_en   <= '0;
            r_im   <= '0;
            r_pend <= '0;
            r_irq  <= 1'b0;
            for (int i = 0; i < N_CH; i++) begin
                r_mode[i]   <= '0;
                r_preset[i] <= '0;
                r_count[i]  <= '0;
            end
        end else begin
            r_irq <= |(r_pend & r_im);
            for (int i = 0; i < N_CH; i++) begin
                if (w_hit[i]) begin
                    unique case (w_reg)
                        REG_CTRL: begin
                            r_en[i]   <= dat_i[0];
                            r_mode[i] <= dat_i[2:1];
                            r_im[i]   <= dat_i[3];
                        end
                        REG_PRESET: begin
                            r_preset[i] <= w_d;
                            r_count[i]  <= w_d;
                            r_pend[i]   <= 1'b0;
                        end
                        REG_COUNT: r_count[i] <= w_d;
                        REG_STATUS: begin
                            if (dat_i[0]) r_pend[i] <= 1'b0;
                        end
                    endcase
                end
                // Terminal event overrides a same-cycle W1C
                if (w_tick[i]) begin
                    if (r_count[i] > CNT_W'(1)) begin
                        r_count[i] <= r_count[i] - CNT_W'(1);
                    end else if (r_count[i] == CNT_W'(1)) begin
                        r_pend[i] <= 1'b1;
                        if (r_mode[i] == 2'b01) begin
                            r_count[i] <= r_preset[i];
                        end else begin
                            r_count[i] <= '0;
                            r_en[i]    <= 1'b0;
                        end
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_coco_timer_mc.sv
// Randomized and directed bench for coco_timer_mc against a
// behavioural channel model.
module tb_coco_timer_mc;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  add = '0;
    logic        we  = 1'b0;
    logic [31:0] dat = '0;
    logic [31:0] dato;
    logic        irq_o;
    logic [3:0]  add2 = '0;
    logic        we2  = 1'b0;
    logic [31:0] dat2 = '0;
    logic [31:0] dato2;
    logic        irq2;

    int ntests = 0;
    int nfail  = 0;

    bit          m_en   [4];
    bit          m_im   [4];
    bit          m_pend [4];
    logic [1:0]  m_mode [4];
    logic [31:0] m_pre  [4];
    logic [31:0] m_cnt  [4];
    bit          m_irq;

    coco_timer_mc #(.N_CH(4), .CNT_W(32), .CH_W(2)) dut (
        .clk_i(clk), .rst_i(rst), .add_i(add), .we_i(we),
        .dat_i(dat), .dat_o(dato), .irq(irq_o));

    coco_timer_mc #(.N_CH(3), .CNT_W(8), .CH_W(2)) dut2 (
        .clk_i(clk), .rst_i(rst), .add_i(add2), .we_i(we2),
        .dat_i(dat2), .dat_o(dato2), .irq(irq2));

    always #25 clk = ~clk;

    function automatic logic [31:0] m_read(int c, int r);
        case (r)
            0:       return {28'd0, m_im[c], m_mode[c], m_en[c]};
            1:       return m_pre[c];
            2:       return m_cnt[c];
            default: return {31'd0, m_pend[c]};
        endcase
    endfunction

    task automatic m_reset();
        for (int c = 0; c < 4; c++) begin
            m_en[c] = 0; m_im[c] = 0; m_pend[c] = 0;
            m_mode[c] = 0; m_pre[c] = 0; m_cnt[c] = 0;
        end
        m_irq = 0;
    endtask

    // One clock edge of the channel rules, applied to the model
    task automatic m_step(bit w, int a, logic [31:0] d);
        bit irq_n;
        irq_n = 0;
        for (int c = 0; c < 4; c++) irq_n |= m_pend[c] & m_im[c];
        for (int c = 0; c < 4; c++) begin
            bit hit, frz, oen;
            logic [1:0] omode;
            logic [31:0] opre, ocnt;
            int r;
            r = a % 4;
            hit = w && ((a / 4) == c);
            oen = m_en[c]; omode = m_mode[c];
            opre = m_pre[c]; ocnt = m_cnt[c];
            frz = hit && (r == 1 || r == 2 || (r == 0 && !d[0]));
            if (hit) begin
                if (r == 0) begin
                    m_en[c] = d[0]; m_mode[c] = d[2:1]; m_im[c] = d[3];
                end else if (r == 1) begin
                    m_pre[c] = d; m_cnt[c] = d; m_pend[c] = 0;
                end else if (r == 2) begin
                    m_cnt[c] = d;
                end else if (d[0]) begin
                    m_pend[c] = 0;
                end
            end
            if (oen && !frz && ocnt != 0) begin
                if (ocnt == 1) begin
                    m_pend[c] = 1;
                    if (omode == 2'b01) m_cnt[c] = opre;
                    else begin m_cnt[c] = 0; m_en[c] = 0; end
                end else begin
                    m_cnt[c] = ocnt - 1;
                end
            end
        end
        m_irq = irq_n;
    endtask

    task automatic cyc(bit w, int a, logic [31:0] d);
        we = w; add = a[3:0]; dat = d;
        @(posedge clk);
        m_step(w, a, d);
        @(negedge clk);
        we = 1'b0; add = '0;
    endtask

    task automatic cyc2(int a, logic [31:0] d);
        we2 = 1'b1; add2 = a[3:0]; dat2 = d;
        @(posedge clk);
        @(negedge clk);
        we2 = 1'b0; add2 = '0;
    endtask

    task automatic rd(int c, int r, output logic [31:0] v);
        add = 4'(c * 4 + r);
        #1 v = dato;
    endtask

    task automatic rd2(int c, int r, output logic [31:0] v);
        add2 = 4'(c * 4 + r);
        #1 v = dato2;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        m_reset();
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        logic [31:0] v;
        @(negedge clk);
        @(negedge clk);
        ntests++;
        if (irq_o !== 1'b0) begin
            $display("FAIL reset_init_irq got %b exp 0", irq_o); nfail++;
        end
        rst = 1'b0;
        m_reset();
        cyc(1, 5, 1);
        cyc(1, 4, 9);
        cyc(1, 1, 5);
        cyc(1, 0, 1);
        cyc(0, 0, 0);
        ntests++;
        if (irq_o !== m_irq) begin
            $display("FAIL pre_reset_irq got %b exp %b", irq_o, m_irq); nfail++;
        end
        rst = 1'b1;
        m_reset();
        #1;
        ntests++;
        if (irq_o !== 1'b0) begin
            $display("FAIL reset_irq got %b exp 0", irq_o); nfail++;
        end
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++) begin
                rd(c, r, v);
                ntests++;
                if (v !== 32'd0) begin
                    $display("FAIL reset_reg ch%0d r%0d got %h exp 0", c, r, v);
                    nfail++;
                end
            end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_oneshot();
        logic [31:0] v;
        cyc(1, 1, 3);
        cyc(1, 0, 9);
        for (int k = 0; k < 6; k++) begin
            rd(0, 2, v);
            ntests++;
            if (v !== 32'((k < 3) ? 3 - k : 0)) begin
                $display("FAIL oneshot_count k=%0d got %0d", k, v); nfail++;
            end
            rd(0, 3, v);
            ntests++;
            if (v !== 32'(k >= 3)) begin
                $display("FAIL oneshot_pend k=%0d got %0d exp %0d", k, v, k >= 3);
                nfail++;
            end
            ntests++;
            if (irq_o !== (k >= 4)) begin
                $display("FAIL oneshot_irq k=%0d got %b exp %b", k, irq_o, k >= 4);
                nfail++;
            end
            cyc(0, 0, 0);
        end
        rd(0, 0, v);
        ntests++;
        if (v !== 32'h8) begin
            $display("FAIL oneshot_ctrl got %h exp 8", v); nfail++;
        end
        cyc(1, 3, 1);
        cyc(0, 0, 0);
    endtask

    task automatic test_autoreload();
        logic [31:0] v;
        cyc(1, 5, 4);
        cyc(1, 4, 11);
        for (int k = 0; k < 14; k++) begin
            rd(1, 2, v);
            ntests++;
            if (v !== 32'(4 - k % 4)) begin
                $display("FAIL reload_count k=%0d got %0d exp %0d", k, v, 4 - k % 4);
                nfail++;
            end
            rd(1, 3, v);
            ntests++;
            if (v !== 32'(k >= 4 && k != 7)) begin
                $display("FAIL reload_pend k=%0d got %0d", k, v); nfail++;
            end
            ntests++;
            if (irq_o !== (k >= 5 && k != 8)) begin
                $display("FAIL reload_irq k=%0d got %b", k, irq_o); nfail++;
            end
            if (k == 6) cyc(1, 7, 1);
            else cyc(0, 0, 0);
        end
        cyc(1, 4, 0);
        cyc(1, 7, 1);
        cyc(0, 0, 0);
    endtask

    task automatic test_collision();
        logic [31:0] v;
        cyc(1, 9, 2);
        cyc(1, 8, 11);
        for (int k = 0; k < 6; k++) begin
            rd(2, 2, v);
            ntests++;
            if (v !== 32'((k % 2 == 0) ? 2 : 1)) begin
                $display("FAIL coll_count k=%0d got %0d", k, v); nfail++;
            end
            rd(2, 3, v);
            ntests++;
            if (v !== 32'(k >= 2)) begin
                $display("FAIL coll_pend k=%0d got %0d exp %0d", k, v, k >= 2);
                nfail++;
            end
            ntests++;
            if (irq_o !== (k >= 3)) begin
                $display("FAIL coll_irq k=%0d got %b exp %b", k, irq_o, k >= 3);
                nfail++;
            end
            if (k == 1 || k == 3) cyc(1, 11, 1);
            else cyc(0, 0, 0);
        end
        cyc(1, 8, 0);
        cyc(1, 11, 1);
        cyc(0, 0, 0);
    endtask

    task automatic test_mask();
        logic [31:0] v;
        cyc(1, 1, 1);
        cyc(1, 0, 1);
        repeat (3) cyc(0, 0, 0);
        rd(0, 3, v);
        ntests++;
        if (v !== 32'd1) begin
            $display("FAIL mask_ch0_pend got %0d exp 1", v); nfail++;
        end
        ntests++;
        if (irq_o !== 1'b0) begin
            $display("FAIL mask_irq_masked got %b exp 0", irq_o); nfail++;
        end
        cyc(1, 13, 2);
        cyc(1, 12, 9);
        repeat (3) cyc(0, 0, 0);
        ntests++;
        if (irq_o !== 1'b1) begin
            $display("FAIL mask_ch3_irq got %b exp 1", irq_o); nfail++;
        end
        cyc(1, 15, 1);
        rd(3, 3, v);
        ntests++;
        if (v !== 32'd0) begin
            $display("FAIL mask_ch3_clear got %0d exp 0", v); nfail++;
        end
        cyc(0, 0, 0);
        ntests++;
        if (irq_o !== 1'b0) begin
            $display("FAIL mask_irq_drop got %b exp 0", irq_o); nfail++;
        end
        rd(0, 3, v);
        ntests++;
        if (v !== 32'd1) begin
            $display("FAIL mask_ch0_kept got %0d exp 1", v); nfail++;
        end
    endtask

    task automatic test_boundary();
        logic [31:0] v;
        cyc(1, 5, 0);
        cyc(1, 4, 11);
        for (int k = 0; k < 10; k++) begin
            rd(1, 3, v);
            ntests++;
            if (v !== 32'd0 || irq_o !== 1'b0) begin
                $display("FAIL preset0 k=%0d pend %0d irq %b exp 0", k, v, irq_o);
                nfail++;
            end
            cyc(0, 0, 0);
        end
        cyc2(2, 32'h1FF);
        rd2(0, 2, v);
        ntests++;
        if (v !== 32'hFF) begin
            $display("FAIL w8_count got %h exp ff", v); nfail++;
        end
        cyc2(1, 32'h1AB);
        rd2(0, 1, v);
        ntests++;
        if (v !== 32'hAB) begin
            $display("FAIL w8_preset got %h exp ab", v); nfail++;
        end
        cyc2(13, 32'h5);
        cyc2(12, 32'hF);
        cyc2(14, 32'h7);
        for (int r = 0; r < 4; r++) begin
            rd2(3, r, v);
            ntests++;
            if (v !== 32'd0) begin
                $display("FAIL ch3_absent r%0d got %h exp 0", r, v); nfail++;
            end
        end
        rd2(0, 0, v);
        ntests++;
        if (v !== 32'd0) begin
            $display("FAIL ch3_leak_ctrl got %h exp 0", v); nfail++;
        end
        rd2(0, 2, v);
        ntests++;
        if (v !== 32'hAB) begin
            $display("FAIL ch3_leak_count got %h exp ab", v); nfail++;
        end
        repeat (3) cyc2(15, 32'h0);
        ntests++;
        if (irq2 !== 1'b0) begin
            $display("FAIL ch3_irq got %b exp 0", irq2); nfail++;
        end
    endtask

    task automatic test_random();
        logic [31:0] v;
        do_reset();
        for (int n = 0; n < 400; n++) begin
            bit w;
            int c, r;
            logic [31:0] d;
            w = ($urandom % 3) != 0;
            c = $urandom_range(0, 3);
            r = $urandom_range(0, 3);
            if (r == 0) d = $urandom & 32'hF;
            else if (r == 3) d = $urandom & 32'h1;
            else if ($urandom % 8 == 0) d = $urandom;
            else d = $urandom % 8;
            if (w && r == 0 && d[0] && m_en[c] && m_cnt[c] == 1 && m_mode[c] != 2'b01)
                w = 0;
            cyc(w, c * 4 + r, d);
            for (int cc = 0; cc < 4; cc++)
                for (int rr = 0; rr < 4; rr++) begin
                    rd(cc, rr, v);
                    ntests++;
                    if (v !== m_read(cc, rr)) begin
                        $display("FAIL rand n=%0d ch%0d r%0d got %h exp %h",
                                 n, cc, rr, v, m_read(cc, rr));
                        nfail++;
                    end
                end
            ntests++;
            if (irq_o !== m_irq) begin
                $display("FAIL rand_irq n=%0d got %b exp %b", n, irq_o, m_irq);
                nfail++;
            end
        end
    endtask

    initial begin
        m_reset();
        test_reset();
        test_oneshot();
        test_autoreload();
        test_collision();
        test_mask();
        test_boundary();
        test_random();
        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule
